addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with per-operation mode select, carry/borrow, signed-overflow and zero flags. It generalises the team's fixed 4-bit combinational subtractor to any width. The carry chain is split into `STAGES` registered slices, and a valid/ready handshake on each side allows backpressure. It sits in the datapath between operand registers and the result writeback.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_slice.sv | 41 ++++
 rtl/addsub_pipe.sv | 93 +++++++++
 tb/tb_addsub_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and width helpers for the pipelined adder/subtractor
package addsub_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  typedef struct packed {
    logic cb;
    logic ovf;
    logic zero;
  } flags_t;
  function automatic int chunk_w(int w, int s);
    return w / s;
  endfunction
  function automatic int skew_w(int w, int s, int k);
    return w - (k + 1) * (w / s);
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one CW-bit adder chunk with registered sum, carry, carry-into-MSB, zero and valid; ports: clk/rst_n, en (advance), v_in/a/b/c_in/z_in in, registered v_q/s_q/c_q/cm_q/z_q out
module addsub_slice #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          v_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          c_in,
  input  logic          z_in,
  output logic          v_q,
  output logic [CW-1:0] s_q,
  output logic          c_q,
  output logic          cm_q,
  output logic          z_q
);
  logic [CW:0] sum;
  logic cm;
  assign sum = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_in};
  // the MSB sum bit is a^b^carry_in, so the carry into the MSB falls out of it
  assign cm = a[CW-1] ^ b[CW-1] ^ sum[CW-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= 1'b0;
      s_q  <= '0;
      c_q  <= 1'b0;
      cm_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (en) begin
      v_q <= v_in;
      if (v_in) begin
        s_q  <= sum[CW-1:0];
        c_q  <= sum[CW];
        cm_q <= cm;
        z_q  <= z_in & ~|sum[CW-1:0];
      end
    end
  end
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: STAGES-deep pipelined add/sub with valid/ready, carry/borrow, overflow and zero flags; ports: clk/rst_n, in_valid/in_ready/a/b/sub in side, out_valid/out_ready/result/cb/ovf/zero out side
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = chunk_w(WIDTH, STAGES);
  logic stall;
  logic [WIDTH-1:0] bx;
  flags_t fl;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign bx = b ^ {WIDTH{sub == OP_SUB}};
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic [CW-1:0] a_c, b_c, s_q;
    logic c_i, z_i, v_i, s_i, v_q, c_q, cm_q, z_q, sb;
    logic [(k+1)*CW-1:0] res;
    if (k == 0) begin : f
      assign a_c = a[CW-1:0];
      assign b_c = bx[CW-1:0];
      assign c_i = sub;
      assign z_i = 1'b1;
      assign v_i = in_valid;
      assign s_i = sub;
      assign res = s_q;
    end else begin : f
      logic [k*CW-1:0] lo;
      assign a_c = g[k-1].sk.a_hi[CW-1:0];
      assign b_c = g[k-1].sk.b_hi[CW-1:0];
      assign c_i = g[k-1].c_q;
      assign z_i = g[k-1].z_q;
      assign v_i = g[k-1].v_q;
      assign s_i = g[k-1].sb;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lo <= '0;
        else if (!stall && v_i) lo <= g[k-1].res;
      end
      assign res = {s_q, lo};
    end
    if (k < STAGES - 1) begin : sk
      localparam int HW = skew_w(WIDTH, STAGES, k);
      logic [HW-1:0] a_hi, b_hi, a_n, b_n;
      logic cm_unused;
      if (k == 0) begin : n
        assign a_n = a[WIDTH-1:CW];
        assign b_n = bx[WIDTH-1:CW];
      end else begin : n
        assign a_n = g[k-1].sk.a_hi[HW+CW-1:CW];
        assign b_n = g[k-1].sk.b_hi[HW+CW-1:CW];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (!stall && v_i) begin
          a_hi <= a_n;
          b_hi <= b_n;
        end
      end
      assign cm_unused = cm_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb <= 1'b0;
      else if (!stall && v_i) sb <= s_i;
    end
    addsub_slice #(.CW(CW)) u_slice (
      .clk(clk), .rst_n(rst_n), .en(!stall), .v_in(v_i), .a(a_c), .b(b_c),
      .c_in(c_i), .z_in(z_i), .v_q(v_q), .s_q(s_q), .c_q(c_q), .cm_q(cm_q), .z_q(z_q)
    );
  end
  assign out_valid = g[STAGES-1].v_q;
  assign result = g[STAGES-1].res;
  // carry out of an inverted-b subtraction is "no borrow", hence the XOR with sub
  assign fl = '{cb: g[STAGES-1].c_q ^ g[STAGES-1].sb,
                ovf: g[STAGES-1].cm_q ^ g[STAGES-1].c_q,
                zero: g[STAGES-1].z_q};
  assign {cb, ovf, zero} = fl;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: randomized and directed checks of addsub_pipe against an arithmetic reference model
module tb_addsub_pipe;
  typedef struct packed {
    logic [31:0] r;
    logic cb;
    logic ovf;
    logic zero;
  } exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  logic in_valid = 0, sub = 0, out_ready = 1;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, cb, ovf, zero;
  logic [15:0] result;
  logic sw_v = 0, sw_s = 0;
  logic [31:0] sw_a = 0, sw_b = 0;
  logic ir1, v1, cb1, ov1, z1, ir8, v8, cb8, ov8, z8, ir32, v32, cb32, ov32, z32;
  logic [7:0] r1, r8;
  logic [31:0] r32;
  logic [15:0] ta[6] = '{16'h0007, 16'h0003, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234};
  logic [15:0] tbv[6] = '{16'h0003, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h1234};
  logic ts[6] = '{1, 1, 1, 0, 0, 1};
  logic [15:0] er[6] = '{16'h0004, 16'hFFFC, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
  logic ecb[6] = '{0, 1, 0, 0, 1, 0};
  logic eov[6] = '{0, 0, 1, 1, 0, 0};
  logic ez[6] = '{0, 0, 0, 0, 1, 1};

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cb(cb), .ovf(ovf), .zero(zero));
  addsub_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(ir1), .a(sw_a[7:0]), .b(sw_b[7:0]), .sub(sw_s),
    .out_valid(v1), .out_ready(1'b1), .result(r1), .cb(cb1), .ovf(ov1), .zero(z1));
  addsub_pipe #(.WIDTH(8), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(ir8), .a(sw_a[7:0]), .b(sw_b[7:0]), .sub(sw_s),
    .out_valid(v8), .out_ready(1'b1), .result(r8), .cb(cb8), .ovf(ov8), .zero(z8));
  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_v), .in_ready(ir32), .a(sw_a), .b(sw_b), .sub(sw_s),
    .out_valid(v32), .out_ready(1'b1), .result(r32), .cb(cb32), .ovf(ov32), .zero(z32));

  function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, logic s);
    longint m = (longint'(1) << w) - 1;
    longint h = longint'(1) << (w - 1);
    longint ux = longint'({32'b0, x}) & m;
    longint uy = longint'({32'b0, y}) & m;
    longint sx = ux >= h ? ux - 2 * h : ux;
    longint sy = uy >= h ? uy - 2 * h : uy;
    longint full = s ? ux - uy : ux + uy;
    longint sr = s ? sx - sy : sx + sy;
    exp_t e;
    e.r = 32'(full & m);
    e.cb = s ? (ux < uy) : (full > m);
    e.ovf = (sr >= h) || (sr < -h);
    e.zero = (full & m) == 0;
    return e;
  endfunction

  task test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (result !== 16'h0) $display("FAIL reset_result got %h want 0000", result); else passes++;
    checks++; if ({cb, ovf, zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {cb, ovf, zero}); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    rst_n = 1;
  endtask

  task test_directed;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1; a = ta[i]; b = tbv[i]; sub = ts[i];
      @(negedge clk);
      in_valid = 0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL dir_early_valid[%0d] got %b want 0", i, out_valid); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL dir_latency[%0d] got %b want 1", i, out_valid); else passes++;
      checks++; if (result !== er[i]) $display("FAIL dir_result[%0d] got %h want %h", i, result, er[i]); else passes++;
      checks++; if (cb !== ecb[i]) $display("FAIL dir_cb[%0d] got %b want %b", i, cb, ecb[i]); else passes++;
      checks++; if (ovf !== eov[i]) $display("FAIL dir_ovf[%0d] got %b want %b", i, ovf, eov[i]); else passes++;
      checks++; if (zero !== ez[i]) $display("FAIL dir_zero[%0d] got %b want %b", i, zero, ez[i]); else passes++;
    end
  endtask

  task test_back_to_back;
    exp_t q[$];
    exp_t e;
    logic st = 0;
    logic [18:0] hold = 0;
    int acc = 0, got = 0;
    for (int c = 0; c < 60 && (c < 20 || q.size() > 0); c++) begin
      @(negedge clk);
      out_ready = !(c >= 8 && c <= 11);
      in_valid = c < 20; a = 16'($urandom); b = 16'($urandom); sub = c % 2 == 1;
      #1;
      checks++; if (in_ready !== ~(out_valid & ~out_ready)) $display("FAIL b2b_in_ready[%0d] got %b want %b", c, in_ready, ~(out_valid & ~out_ready)); else passes++;
      if (st) begin
        checks++; if ({result, cb, ovf, zero} !== hold) $display("FAIL b2b_hold[%0d] got %h want %h", c, {result, cb, ovf, zero}, hold); else passes++;
      end
      st = out_valid & ~out_ready;
      hold = {result, cb, ovf, zero};
      if (out_valid && out_ready) begin
        e = q.size() > 0 ? q.pop_front() : 'x;
        got++;
        checks++; if ({result, cb, ovf, zero} !== {e.r[15:0], e.cb, e.ovf, e.zero}) $display("FAIL b2b_beat[%0d] got %h want %h", got, {result, cb, ovf, zero}, {e.r[15:0], e.cb, e.ovf, e.zero}); else passes++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(16, {16'b0, a}, {16'b0, b}, sub));
        acc++;
      end
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got !== acc || q.size() != 0) $display("FAIL b2b_count got %0d want %0d", got, acc); else passes++;
  endtask

  task test_reset_midflight;
    exp_t e;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; a = 16'($urandom); b = 16'($urandom); sub = i % 2 == 1;
    end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", out_valid); else passes++;
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got %b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_async_ready got %b want 1", in_ready); else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_stale[%0d] got %b want 0", i, out_valid); else passes++;
    end
    in_valid = 1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(0, 1));
    e = model(16, {16'b0, a}, {16'b0, b}, sub);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_new_early got %b want 0", out_valid); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL rst_new_latency got %b want 1", out_valid); else passes++;
    checks++; if ({result, cb, ovf, zero} !== {e.r[15:0], e.cb, e.ovf, e.zero}) $display("FAIL rst_new_beat got %h want %h", {result, cb, ovf, zero}, {e.r[15:0], e.cb, e.ovf, e.zero}); else passes++;
  endtask

  task test_sweep;
    exp_t q1[$], q8[$], q32[$];
    exp_t e;
    for (int c = 0; c < 1012; c++) begin
      @(negedge clk);
      if (v1) begin
        e = q1.size() > 0 ? q1.pop_front() : 'x;
        checks++; if ({r1, cb1, ov1, z1} !== {e.r[7:0], e.cb, e.ovf, e.zero}) $display("FAIL sweep_8_1[%0d] got %h want %h", c, {r1, cb1, ov1, z1}, {e.r[7:0], e.cb, e.ovf, e.zero}); else passes++;
      end
      if (v8) begin
        e = q8.size() > 0 ? q8.pop_front() : 'x;
        checks++; if ({r8, cb8, ov8, z8} !== {e.r[7:0], e.cb, e.ovf, e.zero}) $display("FAIL sweep_8_8[%0d] got %h want %h", c, {r8, cb8, ov8, z8}, {e.r[7:0], e.cb, e.ovf, e.zero}); else passes++;
      end
      if (v32) begin
        e = q32.size() > 0 ? q32.pop_front() : 'x;
        checks++; if ({r32, cb32, ov32, z32} !== {e.r, e.cb, e.ovf, e.zero}) $display("FAIL sweep_32_4[%0d] got %h want %h", c, {r32, cb32, ov32, z32}, {e.r, e.cb, e.ovf, e.zero}); else passes++;
      end
      sw_v = c < 1000; sw_a = $urandom; sw_b = $urandom; sw_s = 1'($urandom_range(0, 1));
      if (sw_v) begin
        q1.push_back(model(8, sw_a, sw_b, sw_s));
        q8.push_back(model(8, sw_a, sw_b, sw_s));
        q32.push_back(model(32, sw_a, sw_b, sw_s));
      end
    end
    sw_v = 0;
    checks++; if (q1.size() + q8.size() + q32.size() != 0) $display("FAIL sweep_drain got %0d left want 0", q1.size() + q8.size() + q32.size()); else passes++;
  endtask

  initial begin
    #2000000 $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_midflight;
    test_sweep;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
